cu_channel_retime_slice: RTL and testbench

- Parametrised multi-channel retiming slice for the CU control layer. It replaces the fixed single-register input/output latching around the CU clusters.
- Provides NUM_CHANNELS independent valid/payload channels. Each channel has a configurable pipeline depth and a credit-guarded skid FIFO.
- Outputs are gated by the enable and by a downstream stall (buffer almost-full). Per-channel occupancy and sticky drop flags are reported on a packed status port.

---
 rtl/cu_channel_retime_slice.sv | 138 +++++++++++++
 tb/tb_cu_channel_retime_slice.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_channel_retime_slice.sv
// Multi-channel retiming slice: per-channel pipeline into a credit-guarded skid FIFO.
// Credit counts FIFO entries plus in-flight beats, so the pipeline never needs to stall.

module cu_channel_retime_lane #(
  parameter int W          = 64,
  parameter int PIPE_DEPTH = 2,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_payload,
  output logic             in_ready,
  input  logic             out_stall,
  output logic             out_valid,
  output logic [W-1:0]     out_payload,
  output logic [CNT_W-1:0] occupancy,
  output logic             drop_sticky
);
  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic [PIPE_DEPTH-1:0]          vld_pipe;
  logic [PIPE_DEPTH-1:0][W-1:0]   dat_pipe;
  logic [SKID_DEPTH-1:0][W-1:0]   mem;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]               count, credit;
  logic                           accept, wr, pop;
  logic [W-1:0]                   wr_data, head;

  assign in_ready  = enabled && !flush && (credit < CNT_W'(SKID_DEPTH));
  assign accept    = in_valid && in_ready;
  assign wr        = vld_pipe[PIPE_DEPTH-1];
  assign wr_data   = dat_pipe[PIPE_DEPTH-1];
  // An empty FIFO forwards the beat being written this cycle.
  assign pop       = ((count != '0) || wr) && enabled && !out_stall;
  assign head      = (count == '0) ? wr_data : mem[rd_ptr];
  assign occupancy = credit;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      dat_pipe    <= '0;
      mem         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      credit      <= '0;
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else begin
      dat_pipe[0] <= in_payload;
      for (int i = 1; i < PIPE_DEPTH; i++) dat_pipe[i] <= dat_pipe[i-1];
      if (flush) begin
        vld_pipe  <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        credit    <= '0;
        out_valid <= 1'b0;
      end else begin
        vld_pipe[0] <= accept;
        for (int i = 1; i < PIPE_DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
        if (wr) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr      <= rd_ptr + PTR_W'(1);
          out_payload <= head;
        end
        out_valid <= pop;
        count     <= count + CNT_W'(wr) - CNT_W'(pop);
        credit    <= credit + CNT_W'(accept) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              drop_sticky <= 1'b0;
    else if (in_valid && !in_ready && enabled) drop_sticky <= 1'b1;
  end
endmodule

module cu_channel_retime_slice #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int PIPE_DEPTH    = 2,
  parameter int SKID_DEPTH    = 4,
  parameter int CNT_W         = $clog2(SKID_DEPTH + 1)
) (
  input  logic                                  clock,
  input  logic                                  rstn_in,
  input  logic                                  enabled_in,
  input  logic                                  flush_in,
  input  logic [NUM_CHANNELS-1:0]               in_valid,
  input  logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] in_payload,
  output logic [NUM_CHANNELS-1:0]               in_ready,
  input  logic [NUM_CHANNELS-1:0]               out_stall,
  output logic [NUM_CHANNELS-1:0]               out_valid,
  output logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] out_payload,
  output logic [NUM_CHANNELS*CNT_W-1:0]         occupancy_out,
  output logic [NUM_CHANNELS-1:0]               drop_sticky
);
  logic rstn_internal, enabled;

  // Asserts with rstn_in, releases one edge later so deassertion is clean.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rstn_internal <= 1'b0;
    else          rstn_internal <= 1'b1;
  end

  always_ff @(posedge clock or negedge rstn_internal) begin
    if (!rstn_internal) enabled <= 1'b0;
    else                enabled <= enabled_in;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    cu_channel_retime_lane #(
      .W(PAYLOAD_WIDTH), .PIPE_DEPTH(PIPE_DEPTH), .SKID_DEPTH(SKID_DEPTH), .CNT_W(CNT_W)
    ) u_lane (
      .clock       (clock),
      .rst_n       (rstn_internal),
      .enabled     (enabled),
      .flush       (flush_in),
      .in_valid    (in_valid[c]),
      .in_payload  (in_payload[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .in_ready    (in_ready[c]),
      .out_stall   (out_stall[c]),
      .out_valid   (out_valid[c]),
      .out_payload (out_payload[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .occupancy   (occupancy_out[c*CNT_W +: CNT_W]),
      .drop_sticky (drop_sticky[c])
    );
  end
endmodule

// File: tb/tb_cu_channel_retime_slice.sv
// Directed scenarios plus random traffic against a queue-based channel model.
module tb_cu_channel_retime_slice;
  localparam int NC = 4, PW = 64, PD = 2, SK = 4, CW = 3;

  logic              clock = 1'b0;
  logic              rstn_in = 1'b1, enabled_in = 1'b0, flush_in = 1'b0;
  logic [NC-1:0]     in_valid = '0, out_stall = '0;
  logic [NC*PW-1:0]  in_payload = '0;
  logic [NC-1:0]     in_ready, out_valid, drop_sticky;
  logic [NC*PW-1:0]  out_payload;
  logic [NC*CW-1:0]  occupancy_out;

  cu_channel_retime_slice #(
    .NUM_CHANNELS(NC), .PAYLOAD_WIDTH(PW), .PIPE_DEPTH(PD), .SKID_DEPTH(SK), .CNT_W(CW)
  ) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_payload(in_payload), .in_ready(in_ready),
    .out_stall(out_stall), .out_valid(out_valid), .out_payload(out_payload),
    .occupancy_out(occupancy_out), .drop_sticky(drop_sticky)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  // Model: each channel is a list of in-flight beats (with age) and a FIFO queue.
  bit          rst_m = 1'b0, en_m = 1'b0;
  logic [PW-1:0] fifo_q[NC][$];
  logic [PW-1:0] fly_d[NC][$];
  int          fly_a[NC][$];
  bit          ov_m[NC];
  logic [PW-1:0] op_m[NC];
  bit          drop_m[NC];

  task automatic chk(input string tag, input logic [NC*PW-1:0] obs, input logic [NC*PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    en_m = 1'b0;
    for (int c = 0; c < NC; c++) begin
      fifo_q[c].delete(); fly_d[c].delete(); fly_a[c].delete();
      ov_m[c] = 1'b0; op_m[c] = '0; drop_m[c] = 1'b0;
    end
  endtask

  task automatic async_reset();
    rstn_in = 1'b0;
    rst_m = 1'b0;
    model_clear();
    #1;
    chk("rst_async_ov",   out_valid, '0);
    chk("rst_async_op",   out_payload, '0);
    chk("rst_async_occ",  occupancy_out, '0);
    chk("rst_async_rdy",  in_ready, '0);
    chk("rst_async_drop", drop_sticky, '0);
  endtask

  task automatic cycle();
    logic [NC-1:0] rdy, acc, pop, dset, e_ov, e_drop, iv, st;
    logic [NC*PW-1:0] e_op, ip;
    logic [NC*CW-1:0] e_occ;
    logic f, en_in, rn;
    int occ;
    @(negedge clock);
    f = flush_in; en_in = enabled_in; rn = rstn_in; iv = in_valid; st = out_stall; ip = in_payload;
    for (int c = 0; c < NC; c++) begin
      while (fly_a[c].size() > 0 && fly_a[c][0] == PD) begin
        fifo_q[c].push_back(fly_d[c].pop_front());
        void'(fly_a[c].pop_front());
      end
      occ = fifo_q[c].size() + fly_d[c].size();
      rdy[c]  = en_m && !f && (occ < SK);
      e_ov[c] = ov_m[c];
      e_op[c*PW +: PW]  = op_m[c];
      e_occ[c*CW +: CW] = CW'(occ);
      e_drop[c] = drop_m[c];
      acc[c]  = iv[c] && rdy[c];
      pop[c]  = (fifo_q[c].size() > 0) && en_m && !st[c] && !f;
      dset[c] = iv[c] && !rdy[c] && en_m;
    end
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, e_ov);
    chk("out_payload", out_payload, e_op);
    chk("occupancy", occupancy_out, e_occ);
    chk("drop_sticky", drop_sticky, e_drop);
    @(posedge clock);
    if (!rst_m) model_clear();
    else begin
      for (int c = 0; c < NC; c++) begin
        if (dset[c]) drop_m[c] = 1'b1;
        if (f) begin
          fifo_q[c].delete(); fly_d[c].delete(); fly_a[c].delete();
          ov_m[c] = 1'b0;
        end else begin
          for (int i = 0; i < fly_a[c].size(); i++) fly_a[c][i] = fly_a[c][i] + 1;
          if (acc[c]) begin
            fly_d[c].push_back(ip[c*PW +: PW]);
            fly_a[c].push_back(1);
          end
          ov_m[c] = pop[c];
          if (pop[c]) op_m[c] = fifo_q[c].pop_front();
        end
      end
      en_m = en_in;
    end
    rst_m = rn;
    #1;
  endtask

  initial begin
    int cnt;
    model_clear();
    #2 rstn_in = 1'b0;
    enabled_in = 1'b1;
    repeat (3) cycle();
    // Reset release: ready two edges later.
    rstn_in = 1'b1;
    cycle();
    chk("rel_rdy1", in_ready, '0);
    cycle();
    chk("rel_rdy2", in_ready, 4'hF);

    // Single-beat latency on ch0.
    in_valid = 4'b0001; in_payload[0 +: PW] = 64'hDEAD_BEEF;
    cycle();
    in_valid = '0;
    cycle(); cycle();
    chk("lat_valid", out_valid[0], 1'b1);
    chk("lat_data", out_payload[0 +: PW], 64'hDEAD_BEEF);
    cycle();
    chk("lat_pulse", out_valid[0], 1'b0);

    // Backpressure on ch1.
    out_stall = 4'b0010; in_valid = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      in_payload[PW +: PW] = 64'(k);
      cycle();
    end
    in_valid = '0;
    cycle(); cycle();
    chk("bp_occ", occupancy_out[CW +: CW], 3'd4);
    chk("bp_rdy", in_ready[1], 1'b0);
    chk("bp_drop", drop_sticky[1], 1'b1);
    out_stall = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("bp_ov", out_valid[1], 1'b1);
      chk("bp_order", out_payload[PW +: PW], 64'(k));
    end
    chk("bp_occ0", occupancy_out[CW +: CW], 3'd0);
    cycle();

    // Disable mid-stream on ch2.
    in_valid = 4'b0100; in_payload[2*PW +: PW] = 64'hA1;
    cycle();
    enabled_in = 1'b0; in_payload[2*PW +: PW] = 64'hA2;
    cycle();
    in_payload[2*PW +: PW] = 64'hA3;
    cycle();
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("dis_no_out", out_valid[2], 1'b0);
      chk("dis_rdy", in_ready[2], 1'b0);
    end
    enabled_in = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (out_valid[2]) cnt++;
    end
    chk("dis_count", 32'(cnt), 32'd2);

    // Flush with ch0/ch3 queued.
    out_stall = 4'b1001; in_valid = 4'b1001;
    in_payload[0 +: PW] = 64'h11; in_payload[3*PW +: PW] = 64'h31;
    cycle();
    in_payload[0 +: PW] = 64'h12; in_payload[3*PW +: PW] = 64'h32;
    cycle();
    in_valid = '0;
    repeat (3) cycle();
    flush_in = 1'b1;
    cycle();
    flush_in = 1'b0;
    chk("flush_occ", occupancy_out, '0);
    out_stall = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("flush_no_out", out_valid, '0);
    end
    in_valid = 4'b1000; in_payload[3*PW +: PW] = 64'h5A5A;
    cycle();
    in_valid = '0;
    cycle(); cycle();
    chk("flush_lat_v", out_valid[3], 1'b1);
    chk("flush_lat_d", out_payload[3*PW +: PW], 64'h5A5A);

    // Reset with 3 queued beats and one in flight on ch0.
    out_stall = 4'b0001; in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      in_payload[0 +: PW] = 64'h70 + 64'(k);
      cycle();
    end
    in_valid = '0;
    repeat (3) cycle();
    in_valid = 4'b0001; in_payload[0 +: PW] = 64'h7F;
    cycle();
    in_valid = '0;
    #2 async_reset();
    repeat (2) cycle();
    rstn_in = 1'b1; out_stall = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rst_no_stale", out_valid, '0);
    end

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      in_valid   = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        out_stall[c] = ($urandom_range(0, 9) < 3);
        in_payload[c*PW +: PW] = {$urandom, $urandom};
      end
      enabled_in = ($urandom_range(0, 19) != 0);
      flush_in   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    in_valid = '0; flush_in = 1'b0; out_stall = '0; enabled_in = 1'b1;
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
